risc_fetch_unit: RTL and testbench
==================================

RISC_FETCH_UNIT -- requirements
Module: risc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2: fetch queue entries, a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 30: word address to instruction memory, equal to pc[31:2].
REQ-006 SHALL have port imem_data, input, 32: instruction word, combinationally valid in the same cycle as imem_addr.
REQ-007 SHALL have port instr_valid, output, 1: the queue head is valid.
REQ-008 SHALL have port instr, output, 32: the queue-head instruction.
REQ-009 SHALL have port instr_pc, output, 32: the byte PC of the queue-head instruction.
REQ-010 SHALL have port instr_ready, input, 1: the consumer accepts the head; a transfer occurs when instr_valid && instr_ready.
REQ-011 SHALL have port redirect_valid, input, 1: a branch or jump redirect request.
REQ-012 SHALL have port redirect_pc, input, 32: redirect target as a byte address.
REQ-013 SHALL have port halted, output, 1: fetch is stopped on a zero word (see Configuration).

Function
REQ-014 The pc register SHALL be 32 bits with bits [1:0] always 0; imem_addr SHALL be driven combinationally from pc.
REQ-015 Each cycle with no redirect, not halted and queue count < QUEUE_DEPTH, the unit SHALL push {pc, imem_data} and set pc <= pc + 4 (modulo 2^32).
REQ-016 When the queue is full, the unit SHALL hold pc and push nothing; a pop in the same cycle SHALL NOT enable a push.
REQ-017 A simultaneous push and pop SHALL leave the count unchanged; a pushed word SHALL first appear at the head the cycle after the push (fetch-to-output latency of 1 cycle).
REQ-018 Queue order SHALL be strict FIFO, with no loss or duplication under any instr_ready pattern.
REQ-019 instr and instr_pc SHALL remain stable while instr_valid && !instr_ready.
REQ-020 On redirect_valid, a transfer in that cycle SHALL still complete; all other entries SHALL be flushed, no push SHALL occur, pc <= {redirect_pc[31:2], 2'b00}, and halted SHALL be cleared.
REQ-021 The unit SHALL have two states, FETCH and HALT; FETCH->HALT occurs only per REQ-026; HALT->FETCH occurs only on redirect or reset.
REQ-022 In HALT, the unit SHALL keep draining queued entries, push nothing and hold pc.

Reset
REQ-023 Reset SHALL override redirect in the same cycle.
REQ-024 On reset the unit SHALL set pc = {RESET_PC[31:2], 2'b00}, queue count = 0, instr_valid = 0, halted = 0 and state = FETCH; instr and instr_pc SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries; the first push SHALL occur in the first cycle with reset low.

Configuration
REQ-026 With FETCH_HALT_ON_ZERO_EN defined, a fetch returning imem_data == 32'h0 SHALL not be pushed, pc SHALL hold, and the state SHALL go to HALT (halted = 1 from the next cycle).
REQ-027 Without FETCH_HALT_ON_ZERO_EN, zero words SHALL be fetched like any other word, halted SHALL be tied to 0, and the HALT state SHALL not exist.

Structure
REQ-028 Shared package risc_pkg SHALL hold: instr_t (32-bit), pc_t (32-bit), the fetch_entry_t struct {pc_t pc; instr_t instr;}, and the RESET_PC default constant.
REQ-029 The FIFO SHALL be a sub-module risc_fetch_queue (parameterised depth, with push, pop, flush, count, full and empty); the pc and state logic SHALL stay in risc_fetch_unit.

Verification
REQ-030 Memory image with words 0x00800093, 0x00108133, 0x00108193, 0x04000213 at pc 0x0, 0x4, 0x8, 0xC; release reset with instr_ready=1 -> the cycle after release gives instr=0x00800093, instr_pc=0x0, then one word per cycle in order.
REQ-031 Hold instr_ready=0 from reset -> imem_addr stops at 2 (pc 0x8), the head holds 0x00800093; raise instr_ready -> 0x00800093, 0x00108133, 0x00108193 follow with no gap or duplicate.
REQ-032 Redirect with redirect_pc=0x0000000E while the queue is full -> queue flushed, next head instr_pc=0x0C, instr=0x04000213.
REQ-033 Assert reset and redirect_valid (target 0x8) together -> pc = RESET_PC, and the first delivered instr_pc = 0x0.
REQ-034 Redirect to 0xFFFFFFFC -> instr_pc sequence 0xFFFFFFFC, then 0x00000000.
REQ-035 Fetch reaches pc 0x18 with a zero word there -> with FETCH_HALT_ON_ZERO_EN: earlier words drain, halted=1, imem_addr holds 6, no zero word is delivered, and a redirect to 0x0 resumes fetch; without the macro: 0x00000000 is delivered at instr_pc=0x18 and halted stays 0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared types for the RISC front end: instruction/PC words, fetch queue entry,
// fetch FSM states and the default reset PC.
package risc_pkg;

    typedef logic [31:0] instr_t;
    typedef logic [31:0] pc_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;

    localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    // Instruction fetch is word aligned; the low two address bits are dropped.
    function automatic pc_t align_pc(input pc_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/risc_fetch_queue.sv
// Power-of-two FIFO of fetch entries with synchronous flush. The head reads
// as all zeros whenever the queue is empty.
module risc_fetch_queue
    import risc_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  fetch_entry_t       data_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    fetch_entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // NOTE: the storage array has no reset; validity lives in count_q and the
    // head is masked when empty, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop sees
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction fetch unit: PC register, redirect handling and an output FIFO.
// Define FETCH_HALT_ON_ZERO_EN to stop fetching when a zero word is read.
module risc_fetch_unit
    import risc_pkg::*;
#(
    parameter pc_t RESET_PC    = RESET_PC_DEFAULT,
    parameter int  QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    pc_t              pc_q, pc_d;
    logic             fetch_en;
    logic             zero_hit;
    logic             push, pop, room;
    logic [CNT_W-1:0] q_count;
    logic             q_full, q_empty;
    fetch_entry_t     q_head;

`ifdef FETCH_HALT_ON_ZERO_EN
    fetch_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        fetch_en = (state_q == FETCH);
        zero_hit = fetch_en && (imem_data == 32'h0);
        if (redirect_valid) begin
            state_d = FETCH;
        end else if (zero_hit) begin
            state_d = HALT;
        end
    end

    assign halted = (state_q == HALT);
`else
    always_comb begin
        fetch_en = 1'b1;
        zero_hit = 1'b0;
    end

    assign halted = 1'b0;
`endif

    // Room is judged on the pre-pop count: a same-cycle pop never frees a slot.
    assign room = (q_count < CNT_W'(QUEUE_DEPTH));
    assign push = fetch_en && !redirect_valid && room && !zero_hit;
    assign pop  = instr_valid && instr_ready;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= align_pc(RESET_PC);
        else       pc_q <= pc_d;
    end

    assign imem_addr = pc_q[31:2];

    risc_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  ('{pc: pc_q, instr: imem_data}),
        .head_o  (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign instr_valid = !q_empty;
    assign instr       = q_head.instr;
    assign instr_pc    = q_head.pc;

    a_full_consistent: assert property (
        @(posedge clk) disable iff (reset)
        q_full == (q_count == CNT_W'(QUEUE_DEPTH))
    );

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Directed bench for risc_fetch_unit with a combinational instruction memory
// model; zero-word expectations follow FETCH_HALT_ON_ZERO_EN.
module tb_risc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] prog [6] = '{32'h0080_0093, 32'h0010_8133, 32'h0010_8193,
                             32'h0400_0213, 32'h0000_0013, 32'h0050_0293};

    risc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    // Words 0..5 hold the program, word 6 (pc 0x18) is zero, all others are
    // a nonzero pattern derived from the word address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a < 30'd6) return prog[a[2:0]];
        if (a == 30'd6) return 32'h0;
        return {2'b10, a};
    endfunction

    assign imem_data = mem_word(imem_addr);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step(2);

        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_addr", {2'b0, imem_addr}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        reset = 1'b0;

        // Streaming with the consumer always ready.
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("stream_valid%0d", k), {31'b0, instr_valid}, 32'd1);
            check($sformatf("stream_instr%0d", k), instr, prog[k]);
            check($sformatf("stream_pc%0d", k), instr_pc, 32'(4 * k));
        end

        // Back-pressure from reset: queue fills, pc stops at 0x8.
        reset       = 1'b1;
        instr_ready = 1'b0;
        step();
        reset = 1'b0;
        check("midrst_valid", {31'b0, instr_valid}, 32'd0);
        step(3);
        check("bp_addr", {2'b0, imem_addr}, 32'd2);
        check("bp_head", instr, prog[0]);
        step();
        check("bp_hold_instr", instr, prog[0]);
        check("bp_hold_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drain_valid%0d", k), {31'b0, instr_valid}, 32'd1);
            check($sformatf("drain_instr%0d", k), instr, prog[k]);
            step();
        end

        // Refill to full, then redirect to an unaligned target.
        instr_ready = 1'b0;
        step(2);
        check("full_addr", {2'b0, imem_addr}, 32'd5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000E;
        step();
        redirect_valid = 1'b0;
        check("redir_flush", {31'b0, instr_valid}, 32'd0);
        check("redir_addr", {2'b0, imem_addr}, 32'd3);
        step();
        check("redir_pc", instr_pc, 32'h0000_000C);
        check("redir_instr", instr, 32'h0400_0213);

        // Reset wins over a same-cycle redirect.
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0008;
        step();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        check("rstredir_addr", {2'b0, imem_addr}, 32'h0);
        check("rstredir_valid", {31'b0, instr_valid}, 32'd0);
        instr_ready = 1'b1;
        step();
        check("rstredir_pc", instr_pc, 32'h0);
        check("rstredir_instr", instr, prog[0]);

        // PC wraps from the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr", {2'b0, imem_addr}, 32'h3FFF_FFFF);
        step();
        check("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
        check("wrap_instr_top", instr, 32'hBFFF_FFFF);
        step();
        check("wrap_pc_zero", instr_pc, 32'h0);
        check("wrap_instr_zero", instr, prog[0]);

        // Run into the zero word at pc 0x18.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("zrun_pc%0d", k), instr_pc, 32'(4 * k));
            check($sformatf("zrun_instr%0d", k), instr, prog[k]);
        end
        step();
`ifdef FETCH_HALT_ON_ZERO_EN
        check("halt_valid", {31'b0, instr_valid}, 32'd0);
        check("halt_flag", {31'b0, halted}, 32'd1);
        check("halt_addr", {2'b0, imem_addr}, 32'd6);
        step();
        check("halt_hold_valid", {31'b0, instr_valid}, 32'd0);
        check("halt_hold_flag", {31'b0, halted}, 32'd1);
        check("halt_hold_addr", {2'b0, imem_addr}, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("resume_halted", {31'b0, halted}, 32'd0);
        step();
        check("resume_valid", {31'b0, instr_valid}, 32'd1);
        check("resume_pc", instr_pc, 32'h0);
        check("resume_instr", instr, prog[0]);
`else
        check("zero_valid", {31'b0, instr_valid}, 32'd1);
        check("zero_pc", instr_pc, 32'h0000_0018);
        check("zero_instr", instr, 32'h0);
        check("zero_halted", {31'b0, halted}, 32'd0);
        step();
        check("post_zero_pc", instr_pc, 32'h0000_001C);
        check("post_zero_instr", instr, 32'h8000_0007);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
